ct_fadd_vec_dp: RTL and testbench
=================================

CT_FADD_VEC_DP -- requirements
Module: ct_fadd_vec_dp

Interface
REQ-001 SHALL have parameter LANES, default 2, number of 64-bit FP lanes (1, 2 or 4).
REQ-002 SHALL have parameter VLEN, fixed to 64*LANES, the vector width in bits.
REQ-003 SHALL have port ex1_pipe_clk  in  1  clock; port cpurst_b  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ex1_pipedown / ex2_pipedown / ex3_pipedown  in  1 each  stage advance strobes.
REQ-005 SHALL have port dp_vfalu_ex1_pipex_func  in  20  op code: [16] double, [15] single, [12] add, [11] sub, [10] cmp, [9] max, [8] min, [4] signalling, [3:0] cmp condition / abs flag.
REQ-006 SHALL have ports dp_vfalu_ex1_pipex_imm0  in  3  static rm; vfpu_yy_xx_rm  in  3  dynamic rm.
REQ-007 SHALL have ports dp_vfalu_ex1_vmask  in  LANES  lane enable; dp_vfalu_ex1_vdst_old  in  VLEN  old destination.
REQ-008 SHALL have ports ex3_lane_result  in  VLEN and ex3_lane_expt  in  5*LANES  per-lane datapath results and flags.
REQ-009 SHALL have outputs ex1_op  6  {mmabs,max,min,cmp,sub,add}; ex1_cmp_op  11  one-hot condition; ex2_op  6; ex2_rm  5  one-hot {rmm,rup,rdn,rtz,rne}; ex2_fmt  3  one-hot {half,single,double}; ex2_lane_vld  LANES; ex2_signal  1.
REQ-010 SHALL have outputs fadd_forward_result  VLEN, fadd_ereg_ex3_result  5, fadd_forward_r_vld  1.

Function
REQ-011 rm SHALL resolve to vfpu_yy_xx_rm when imm0==3'b111, else imm0; codes 5-6 SHALL yield all-zero ex2_rm.
REQ-012 Format SHALL be double if func[16], single if func[15] (func[16] wins), else half.
REQ-013 ex1_cmp_op bit k SHALL be ex1_op[2] && func[3:0]==k for k=0..10; codes 11-15 SHALL yield zero.
REQ-014 ex1 decode SHALL be combinational, zero latency.
REQ-015 Stage valids ex2_vld/ex3_vld SHALL be set by ex1_pipedown/ex2_pipedown and cleared when the stage drains without refill; simultaneous drain and refill SHALL keep the stage valid.
REQ-016 EX2 registers (op, cmp_op, rm, fmt, signal, vmask, vdst_old) SHALL load only on ex1_pipedown and otherwise hold.
REQ-017 EX3 registers (fmt, cmp, vmask, vdst_old) SHALL load only on ex2_pipedown and otherwise hold.
REQ-018 ex2_lane_vld SHALL equal registered vmask ANDed with ex2_vld.
REQ-019 Per enabled lane: double -> ex3 lane result; single -> {32 box, low 32}; half -> {48 box, low 16}; box SHALL be all ones for non-cmp, all zeros for cmp.
REQ-020 Disabled lanes SHALL output the EX3 copy of vdst_old unchanged.
REQ-021 fadd_ereg_ex3_result SHALL be the OR of ex3_lane_expt over enabled lanes only; all lanes disabled -> 5'b0.
REQ-022 fadd_forward_r_vld SHALL equal ex3_pipedown && ex3_vld; result and flags SHALL be valid in that cycle.
REQ-023 Total latency ex1 issue -> forward SHALL be 2 pipedown-gated cycles; stalls SHALL hold all stage contents.

Reset
REQ-024 On cpurst_b low all registers SHALL clear asynchronously; all outputs derived from registers SHALL be 0; an in-flight op SHALL be discarded and not forwarded after reset release.

Configuration
REQ-025 With FADD_VEC_HALF_EN defined, half format SHALL be supported per REQ-012/019.
REQ-026 Without FADD_VEC_HALF_EN, non-double non-single ops SHALL be treated as single, ex2_fmt[2] SHALL be tied 0, and half boxing logic SHALL be absent.

Structure
REQ-027 Func bit positions, rm codes, cmp condition codes and fmt one-hot encodings SHALL live in package ct_fadd_vec_pkg.
REQ-028 Per-lane boxing/merge SHALL be sub-module ct_fadd_vec_lane_merge, instantiated LANES times via generate.

Verification
REQ-029 imm0=3'b111, vfpu_yy_xx_rm=3'b010, add, ex1_pipedown -> next cycle ex2_rm=5'b00100, ex2_op=6'b000001.
REQ-030 LANES=2, single add, vmask=2'b01, lane0 low32=0x3F800000, vdst_old upper=0xAAAA...; two pipedowns -> forward[63:0]=0xFFFFFFFF3F800000, forward[127:64]=0xAAAAAAAAAAAAAAAA.
REQ-031 Half cmp, lane result 0x0001 -> lane output 0x0000000000000001.
REQ-032 vmask=2'b10, lane0 expt=5'b10000, lane1 expt=5'b00001 -> fadd_ereg_ex3_result=5'b00001.
REQ-033 Op in EX2, ex2_pipedown held low 3 cycles -> ex2 outputs stable, fadd_forward_r_vld stays 0; cpurst_b pulsed mid-stall -> no forward after release.
REQ-034 Back-to-back ops with all pipedowns high each cycle -> one forward per cycle, in order, no bubbles.

Source files
------------

// File: rtl/ct_fadd_vec_pkg.sv
// Shared encodings for the vector FP add/compare datapath control slice.
package ct_fadd_vec_pkg;

    localparam int unsigned FuncDouble = 16;
    localparam int unsigned FuncSingle = 15;
    localparam int unsigned FuncAdd    = 12;
    localparam int unsigned FuncSub    = 11;
    localparam int unsigned FuncCmp    = 10;
    localparam int unsigned FuncMax    = 9;
    localparam int unsigned FuncMin    = 8;
    localparam int unsigned FuncSignal = 4;
    // Low condition bit doubles as the abs flag for max/min ops.
    localparam int unsigned FuncAbs    = 0;

    localparam int unsigned CmpNum = 11;

    typedef enum logic [2:0] {
        RmRne = 3'd0,
        RmRtz = 3'd1,
        RmRdn = 3'd2,
        RmRup = 3'd3,
        RmRmm = 3'd4,
        RmDyn = 3'd7
    } rm_e;

    localparam logic [2:0] FmtDouble = 3'b001;
    localparam logic [2:0] FmtSingle = 3'b010;
    localparam logic [2:0] FmtHalf   = 3'b100;

    function automatic logic [4:0] rm_onehot(input logic [2:0] rm);
        logic [4:0] oh;
        case (rm)
            RmRne:   oh = 5'b00001;
            RmRtz:   oh = 5'b00010;
            RmRdn:   oh = 5'b00100;
            RmRup:   oh = 5'b01000;
            RmRmm:   oh = 5'b10000;
            default: oh = 5'b00000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/ct_fadd_vec_lane_merge.sv
// One 64-bit lane of the EX3 result merge: NaN-boxing by format, or old
// destination passthrough when the lane is masked off. Half support: FADD_VEC_HALF_EN.
module ct_fadd_vec_lane_merge
    import ct_fadd_vec_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic        cmp,
    input  logic        en,
    input  logic [63:0] lane_result,
    input  logic [63:0] vdst_old,
    output logic [63:0] lane_out
);

    always_comb begin
        lane_out = vdst_old;
        if (en) begin
            unique case (1'b1)
                fmt[0]: lane_out = lane_result;
`ifdef FADD_VEC_HALF_EN
                fmt[1]: lane_out = {{32{~cmp}}, lane_result[31:0]};
                fmt[2]: lane_out = {{48{~cmp}}, lane_result[15:0]};
`else
                // fmt[2] is tied low in this build.
                fmt[1], fmt[2]: lane_out = {{32{~cmp}}, lane_result[31:0]};
`endif
                default: lane_out = vdst_old;
            endcase
        end
    end

endmodule

// File: rtl/ct_fadd_vec_dp.sv
// Vector FP add/compare control datapath: ex1 decode, ex2/ex3 staging and result merge.
// Half-precision support is enabled by defining FADD_VEC_HALF_EN.
module ct_fadd_vec_dp
    import ct_fadd_vec_pkg::*;
#(
    parameter  int unsigned LANES = 2,
    localparam int unsigned VLEN  = 64 * LANES
) (
    input  logic                 ex1_pipe_clk,
    input  logic                 cpurst_b,
    input  logic                 ex1_pipedown,
    input  logic                 ex2_pipedown,
    input  logic                 ex3_pipedown,
    input  logic [19:0]          dp_vfalu_ex1_pipex_func,
    input  logic [2:0]           dp_vfalu_ex1_pipex_imm0,
    input  logic [2:0]           vfpu_yy_xx_rm,
    input  logic [LANES-1:0]     dp_vfalu_ex1_vmask,
    input  logic [VLEN-1:0]      dp_vfalu_ex1_vdst_old,
    input  logic [VLEN-1:0]      ex3_lane_result,
    input  logic [5*LANES-1:0]   ex3_lane_expt,
    output logic [5:0]           ex1_op,
    output logic [10:0]          ex1_cmp_op,
    output logic [5:0]           ex2_op,
    output logic [4:0]           ex2_rm,
    output logic [2:0]           ex2_fmt,
    output logic [LANES-1:0]     ex2_lane_vld,
    output logic                 ex2_signal,
    output logic [VLEN-1:0]      fadd_forward_result,
    output logic [4:0]           fadd_ereg_ex3_result,
    output logic                 fadd_forward_r_vld
);

    logic [19:0] func;
    logic [2:0]  ex1_rm;
    logic [2:0]  ex1_fmt;

    logic             ex2_vld_q, ex3_vld_q;
    logic [5:0]       ex2_op_q;
    logic [10:0]      ex2_cmp_op_q;
    logic [4:0]       ex2_rm_q;
    logic [2:0]       ex2_fmt_q;
    logic             ex2_signal_q;
    logic [LANES-1:0] ex2_vmask_q;
    logic [VLEN-1:0]  ex2_vdst_old_q;
    logic [2:0]       ex3_fmt_q;
    logic             ex3_cmp_q;
    logic [LANES-1:0] ex3_vmask_q;
    logic [VLEN-1:0]  ex3_vdst_old_q;

    assign func = dp_vfalu_ex1_pipex_func;

    always_comb begin
        ex1_op = {(func[FuncMax] | func[FuncMin]) & func[FuncAbs], func[FuncMax], func[FuncMin],
                  func[FuncCmp], func[FuncSub], func[FuncAdd]};
        for (int k = 0; k < CmpNum; k++) begin
            ex1_cmp_op[k] = ex1_op[2] && (func[3:0] == k[3:0]);
        end
        ex1_rm = (dp_vfalu_ex1_pipex_imm0 == RmDyn) ? vfpu_yy_xx_rm : dp_vfalu_ex1_pipex_imm0;
        if (func[FuncDouble]) begin
            ex1_fmt = FmtDouble;
        end else if (func[FuncSingle]) begin
            ex1_fmt = FmtSingle;
        end else begin
`ifdef FADD_VEC_HALF_EN
            ex1_fmt = FmtHalf;
`else
            ex1_fmt = FmtSingle;
`endif
        end
    end

    always_ff @(posedge ex1_pipe_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ex2_vld_q      <= 1'b0;
            ex3_vld_q      <= 1'b0;
            ex2_op_q       <= '0;
            ex2_cmp_op_q   <= '0;
            ex2_rm_q       <= '0;
            ex2_fmt_q      <= '0;
            ex2_signal_q   <= 1'b0;
            ex2_vmask_q    <= '0;
            ex2_vdst_old_q <= '0;
            ex3_fmt_q      <= '0;
            ex3_cmp_q      <= 1'b0;
            ex3_vmask_q    <= '0;
            ex3_vdst_old_q <= '0;
        end else begin
            // A stage stays valid on drain-and-refill in the same cycle.
            ex2_vld_q <= ex1_pipedown | (ex2_vld_q & ~ex2_pipedown);
            ex3_vld_q <= ex2_pipedown | (ex3_vld_q & ~ex3_pipedown);
            if (ex1_pipedown) begin
                ex2_op_q       <= ex1_op;
                ex2_cmp_op_q   <= ex1_cmp_op;
                ex2_rm_q       <= rm_onehot(ex1_rm);
                ex2_fmt_q      <= ex1_fmt;
                ex2_signal_q   <= func[FuncSignal];
                ex2_vmask_q    <= dp_vfalu_ex1_vmask;
                ex2_vdst_old_q <= dp_vfalu_ex1_vdst_old;
            end
            if (ex2_pipedown) begin
                ex3_fmt_q      <= ex2_fmt_q;
                ex3_cmp_q      <= ex2_op_q[2];
                ex3_vmask_q    <= ex2_vmask_q;
                ex3_vdst_old_q <= ex2_vdst_old_q;
            end
        end
    end

    assign ex2_op       = ex2_op_q;
    assign ex2_rm       = ex2_rm_q;
    assign ex2_fmt      = ex2_fmt_q;
    assign ex2_signal   = ex2_signal_q;
    assign ex2_lane_vld = ex2_vmask_q & {LANES{ex2_vld_q}};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        ct_fadd_vec_lane_merge u_merge (
            .fmt         (ex3_fmt_q),
            .cmp         (ex3_cmp_q),
            .en          (ex3_vmask_q[i]),
            .lane_result (ex3_lane_result[64*i +: 64]),
            .vdst_old    (ex3_vdst_old_q[64*i +: 64]),
            .lane_out    (fadd_forward_result[64*i +: 64])
        );
    end

    always_comb begin
        fadd_ereg_ex3_result = '0;
        for (int i = 0; i < LANES; i++) begin
            if (ex3_vmask_q[i]) begin
                fadd_ereg_ex3_result = fadd_ereg_ex3_result | ex3_lane_expt[5*i +: 5];
            end
        end
    end

    assign fadd_forward_r_vld = ex3_pipedown & ex3_vld_q;

    logic unused_sig;
    assign unused_sig = ^{func[19:17], func[14:13], func[7:5], ex2_cmp_op_q};

endmodule

// File: tb/tb_ct_fadd_vec_dp.sv
// Scoreboard bench for ct_fadd_vec_dp: random and directed ops checked against a lane-level model.
module tb_ct_fadd_vec_dp;

    localparam int LANES = 2;
    localparam int VLEN  = 64 * LANES;

    logic                ex1_pipe_clk;
    logic                cpurst_b;
    logic                ex1_pipedown, ex2_pipedown, ex3_pipedown;
    logic [19:0]         dp_vfalu_ex1_pipex_func;
    logic [2:0]          dp_vfalu_ex1_pipex_imm0;
    logic [2:0]          vfpu_yy_xx_rm;
    logic [LANES-1:0]    dp_vfalu_ex1_vmask;
    logic [VLEN-1:0]     dp_vfalu_ex1_vdst_old;
    logic [VLEN-1:0]     ex3_lane_result;
    logic [5*LANES-1:0]  ex3_lane_expt;
    logic [5:0]          ex1_op;
    logic [10:0]         ex1_cmp_op;
    logic [5:0]          ex2_op;
    logic [4:0]          ex2_rm;
    logic [2:0]          ex2_fmt;
    logic [LANES-1:0]    ex2_lane_vld;
    logic                ex2_signal;
    logic [VLEN-1:0]     fadd_forward_result;
    logic [4:0]          fadd_ereg_ex3_result;
    logic                fadd_forward_r_vld;

    ct_fadd_vec_dp #(.LANES(LANES)) dut (
        .ex1_pipe_clk            (ex1_pipe_clk),
        .cpurst_b                (cpurst_b),
        .ex1_pipedown            (ex1_pipedown),
        .ex2_pipedown            (ex2_pipedown),
        .ex3_pipedown            (ex3_pipedown),
        .dp_vfalu_ex1_pipex_func (dp_vfalu_ex1_pipex_func),
        .dp_vfalu_ex1_pipex_imm0 (dp_vfalu_ex1_pipex_imm0),
        .vfpu_yy_xx_rm           (vfpu_yy_xx_rm),
        .dp_vfalu_ex1_vmask      (dp_vfalu_ex1_vmask),
        .dp_vfalu_ex1_vdst_old   (dp_vfalu_ex1_vdst_old),
        .ex3_lane_result         (ex3_lane_result),
        .ex3_lane_expt           (ex3_lane_expt),
        .ex1_op                  (ex1_op),
        .ex1_cmp_op              (ex1_cmp_op),
        .ex2_op                  (ex2_op),
        .ex2_rm                  (ex2_rm),
        .ex2_fmt                 (ex2_fmt),
        .ex2_lane_vld            (ex2_lane_vld),
        .ex2_signal              (ex2_signal),
        .fadd_forward_result     (fadd_forward_result),
        .fadd_ereg_ex3_result    (fadd_ereg_ex3_result),
        .fadd_forward_r_vld      (fadd_forward_r_vld)
    );

    initial ex1_pipe_clk = 1'b0;
    always #5 ex1_pipe_clk = ~ex1_pipe_clk;

    typedef struct {
        logic [19:0]        func;
        logic [2:0]         imm0;
        logic [2:0]         dyn;
        logic [LANES-1:0]   vmask;
        logic [VLEN-1:0]    old;
        logic [VLEN-1:0]    res;
        logic [5*LANES-1:0] expt;
    } op_t;

    typedef struct {
        logic [VLEN-1:0] res;
        logic [4:0]      flags;
    } fwd_t;

    fwd_t exp_q[$];
    op_t  s2, s3, cur, idle, o;
    bit   s2v, s3v, p1, p2, p3, run;
    int   vectors, miscompares;

    function automatic logic [2:0] ref_fmt(input logic [19:0] f);
        if (f[16]) return 3'b001;
        if (f[15]) return 3'b010;
`ifdef FADD_VEC_HALF_EN
        return 3'b100;
`else
        return 3'b010;
`endif
    endfunction

    function automatic logic [4:0] ref_rm(input logic [2:0] imm0, input logic [2:0] dyn);
        int code;
        code = (imm0 == 3'd7) ? int'(dyn) : int'(imm0);
        return (code <= 4) ? 5'(1 << code) : 5'd0;
    endfunction

    function automatic logic [5:0] ref_op(input logic [19:0] f);
        return {(f[9] | f[8]) & f[0], f[9], f[8], f[10], f[11], f[12]};
    endfunction

    function automatic logic [10:0] ref_cmp(input logic [19:0] f);
        logic [10:0] r;
        int          c;
        r = '0;
        c = int'(f[3:0]);
        if (f[10] && c < 11) r[c] = 1'b1;
        return r;
    endfunction

    function automatic fwd_t ref_fwd(input op_t op);
        fwd_t        e;
        logic [63:0] r;
        logic [2:0]  fmt;
        logic        b;
        e.flags = '0;
        fmt = ref_fmt(op.func);
        b = ~op.func[10];
        for (int i = 0; i < LANES; i++) begin
            r = op.res[64*i +: 64];
            if (!op.vmask[i])    e.res[64*i +: 64] = op.old[64*i +: 64];
            else if (fmt[0])     e.res[64*i +: 64] = r;
            else if (fmt[2])     e.res[64*i +: 64] = {{48{b}}, r[15:0]};
            else                 e.res[64*i +: 64] = {{32{b}}, r[31:0]};
            if (op.vmask[i]) e.flags = e.flags | op.expt[5*i +: 5];
        end
        return e;
    endfunction

    function automatic op_t rand_op();
        op_t r;
        r.func  = 20'($urandom);
        r.imm0  = 3'($urandom);
        r.dyn   = 3'($urandom);
        r.vmask = LANES'($urandom);
        r.old   = {$urandom, $urandom, $urandom, $urandom};
        r.res   = {$urandom, $urandom, $urandom, $urandom};
        r.expt  = 10'($urandom);
        return r;
    endfunction

    task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit a, input bit b, input bit c, input op_t op);
        p1 = a; p2 = b; p3 = c;
        ex1_pipedown = a;
        ex2_pipedown = b;
        ex3_pipedown = c;
        dp_vfalu_ex1_pipex_func = op.func;
        dp_vfalu_ex1_pipex_imm0 = op.imm0;
        vfpu_yy_xx_rm           = op.dyn;
        dp_vfalu_ex1_vmask      = op.vmask;
        dp_vfalu_ex1_vdst_old   = op.old;
        if (s3v) begin
            ex3_lane_result = s3.res;
            ex3_lane_expt   = s3.expt;
        end else begin
            ex3_lane_result = {$urandom, $urandom, $urandom, $urandom};
            ex3_lane_expt   = 10'($urandom);
        end
        if (a) exp_q.push_back(ref_fwd(op));
        cur = op;
    endtask

    task automatic advance();
        @(posedge ex1_pipe_clk);
        #1;
        if (p3) s3v = 1'b0;
        if (p2) begin s3 = s2; s3v = s2v; s2v = 1'b0; end
        if (p1) begin s2 = cur; s2v = 1'b1; end
    endtask

    // Issue an op and walk it to EX3; returns at the negedge of its forward cycle.
    task automatic to_ex3(input op_t op);
        drive(1, 0, 0, op); advance();
        drive(0, 1, 0, idle); advance();
        drive(0, 0, 1, idle);
        @(negedge ex1_pipe_clk);
        #1;
    endtask

    always @(negedge ex1_pipe_clk) begin
        fwd_t e;
        if (run && cpurst_b) begin
            chk("ex1_op", ex1_op, ref_op(dp_vfalu_ex1_pipex_func));
            chk("ex1_cmp_op", ex1_cmp_op, ref_cmp(dp_vfalu_ex1_pipex_func));
            if (s2v) begin
                chk("ex2_op", ex2_op, ref_op(s2.func));
                chk("ex2_rm", ex2_rm, ref_rm(s2.imm0, s2.dyn));
                chk("ex2_fmt", ex2_fmt, ref_fmt(s2.func));
                chk("ex2_signal", ex2_signal, s2.func[4]);
                chk("ex2_lane_vld", ex2_lane_vld, s2.vmask);
            end else begin
                chk("ex2_lane_vld_idle", ex2_lane_vld, '0);
            end
            chk("fwd_vld", fadd_forward_r_vld, p3 && s3v);
            if (fadd_forward_r_vld) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL fwd_unexpected: got forward, expected none at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("fwd_result", fadd_forward_result, e.res);
                    chk("fwd_flags", fadd_ereg_ex3_result, e.flags);
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ex2_op"}, ex2_op, '0);
        chk({tag, "_ex2_rm"}, ex2_rm, '0);
        chk({tag, "_ex2_fmt"}, ex2_fmt, '0);
        chk({tag, "_ex2_lane_vld"}, ex2_lane_vld, '0);
        chk({tag, "_ex2_signal"}, ex2_signal, '0);
        chk({tag, "_fwd_vld"}, fadd_forward_r_vld, '0);
        chk({tag, "_fwd_result"}, fadd_forward_result, '0);
        chk({tag, "_ereg"}, fadd_ereg_ex3_result, '0);
    endtask

    initial begin
        bit a1, a2, a3;
        vectors = 0; miscompares = 0; run = 0;
        s2v = 0; s3v = 0;
        idle = '{func: '0, imm0: '0, dyn: '0, vmask: '0, old: '0, res: '0, expt: '0};
        cpurst_b = 1'b0;
        drive(0, 0, 1, idle);
        #22;
        chk_reset_outputs("reset");
        @(negedge ex1_pipe_clk);
        cpurst_b = 1'b1;
        drive(0, 0, 0, idle);
        @(posedge ex1_pipe_clk);
        #1;
        run = 1;

        // Dynamic rm selection and add decode.
        o = idle; o.func = 20'h01000; o.imm0 = 3'b111; o.dyn = 3'b010;
        drive(1, 0, 0, o); advance();
        drive(0, 0, 0, idle);
        @(negedge ex1_pipe_clk);
        #1;
        chk("dyn_rm", ex2_rm, 5'b00100);
        chk("add_op", ex2_op, 6'b000001);
        advance();
        drive(0, 1, 0, idle); advance();
        drive(0, 0, 1, idle); advance();

        // Single add, lane 1 masked off.
        o = idle; o.func = 20'h09000; o.vmask = 2'b01;
        o.old = {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};
        o.res = {64'h0123_4567_89AB_CDEF, 64'h1234_5678_3F80_0000};
        to_ex3(o);
        chk("single_lo", fadd_forward_result[63:0], 64'hFFFF_FFFF_3F80_0000);
        chk("single_hi", fadd_forward_result[127:64], 64'hAAAA_AAAA_AAAA_AAAA);
        advance();

        // Half compare: zero box.
        o = idle; o.func = 20'h00400; o.vmask = 2'b01;
        o.res = {64'h0, 64'hDEAD_BEEF_0000_0001};
        to_ex3(o);
        chk("half_cmp", fadd_forward_result[63:0], 64'h0000_0000_0000_0001);
        advance();

        // Flags only from enabled lanes.
        o = idle; o.func = 20'h11000; o.vmask = 2'b10; o.expt = {5'b00001, 5'b10000};
        to_ex3(o);
        chk("ereg_mask", fadd_ereg_ex3_result, 5'b00001);
        advance();

        // EX2 stall, then reset mid-stall discards the op.
        drive(1, 0, 0, rand_op()); advance();
        repeat (3) begin drive(0, 0, 0, idle); advance(); end
        cpurst_b = 1'b0;
        s2v = 0; s3v = 0;
        exp_q.delete();
        #2;
        chk_reset_outputs("midreset");
        cpurst_b = 1'b1;
        repeat (4) begin drive(0, 0, 1, idle); advance(); end

        // Back-to-back full-throughput stream.
        drive(1, 0, 0, rand_op()); advance();
        drive(1, 1, 0, rand_op()); advance();
        repeat (8) begin drive(1, 1, 1, rand_op()); advance(); end
        drive(0, 1, 1, idle); advance();
        drive(0, 0, 1, idle); advance();

        // Random stalls with legal pipedown sequencing.
        repeat (400) begin
            a3 = s3v && ($urandom_range(0, 3) != 0);
            a2 = s2v && (!s3v || a3) && ($urandom_range(0, 3) != 0);
            a1 = (!s2v || a2) && ($urandom_range(0, 2) != 0);
            drive(a1, a2, a3, rand_op());
            advance();
        end
        repeat (4) begin drive(0, s2v, s3v, idle); advance(); end
        run = 0;
        chk("drain_empty", VLEN'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
